instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a program load; sampled only in IDLE.
REQ-005 base_addr  input  32  byte address of the first instruction word.
REQ-006 prog_len  input  16  number of instruction words to emit.
REQ-007 in_valid  input  1  an instruction descriptor is present.
REQ-008 in_ready  output  1  the descriptor is consumed this cycle.
REQ-009 in_mnem  input  5  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 J, 7 BEQ, 8 ADDI, 9 SLTI, 10 ANDI, 11 ORI, 12 XORI, 13 LUI, 14 LW, 15 SW; 16-31 illegal.
REQ-010 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-011 in_imm  input  16  immediate/offset field.
REQ-012 in_target  input  26  jump target field.
REQ-013 out_valid  output  1  out_instr/out_addr hold a word for instruction-memory write.
REQ-014 out_ready  input  1  the sink accepts the word.
REQ-015 out_instr  output  32  encoded instruction word.
REQ-016 out_addr  output  32  byte address for out_instr.
REQ-017 err  output  1  one-cycle pulse when an illegal mnemonic is consumed.
REQ-018 done  output  1  one-cycle pulse when the load completes.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 In IDLE, start=1 with prog_len!=0 SHALL latch cur_addr=base_addr and remaining=prog_len, then go to RUN.
REQ-021 In IDLE, start=1 with prog_len=0 SHALL go directly to DONE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 in_ready SHALL equal (state==RUN) && (remaining!=0) && (!out_valid || out_ready).
REQ-024 No descriptor SHALL be consumed in any other case.
REQ-025 A legal descriptor consumed on cycle N SHALL produce the following on cycle N+1, giving one-cycle latency:
- out_valid=1;
- out_instr=encoding;
- out_addr=cur_addr.
REQ-026 On the same consume edge, cur_addr SHALL advance by 4 (wrapping modulo 2^32) and remaining SHALL decrement by 1.
REQ-027 R-type (mnem 0-5) SHALL encode as {6'h00, rs, rt, rd, 5'b0, funct}, with funct:
- ADD 0x20, SUB 0x22, AND 0x24, OR 0x25;
- XOR 0x26, SLT 0x2A.
REQ-028 J SHALL encode as {6'h02, target}.
REQ-029 I-type SHALL encode as {op, rs, rt, imm}, with op:
- BEQ 0x04, ADDI 0x08, SLTI 0x0A, ANDI 0x0C;
- ORI 0x0D, XORI 0x0E, LUI 0x0F, LW 0x23, SW 0x2B.
REQ-030 For LUI, the rs field SHALL be forced to 0.
REQ-031 For J, the rs/rt/rd/imm inputs SHALL be ignored; for R-type, imm/target SHALL be ignored.
REQ-032 A consumed illegal mnemonic (16-31) SHALL pulse err for exactly one cycle (cycle N+1).
REQ-033 A consumed illegal mnemonic SHALL produce no output word and SHALL leave cur_addr and remaining unchanged.
REQ-034 While out_valid=1 and out_ready=0, out_instr and out_addr SHALL hold stable.
REQ-035 out_valid SHALL clear on a transfer unless a new word is loaded on the same edge (back-to-back, one word per cycle).
REQ-036 RUN SHALL go to DONE on the first edge where remaining==0 and the output slot is empty or transferring.
REQ-037 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-038 in_valid=1 in IDLE or DONE SHALL not be consumed (in_ready=0).

Reset
REQ-039 reset=1 at a clock edge SHALL force the following, overriding any in-flight word or state:
- state=IDLE;
- out_valid=0, out_instr=0, out_addr=0;
- err=0, done=0, in_ready=0;
- cur_addr=0, remaining=0.
REQ-040 Reset asserted mid-RUN SHALL discard the pending output word without a transfer and SHALL NOT pulse done.

Verification
REQ-041 start, base_addr=0x00400000, prog_len=1; ADD rs=1, rt=2, rd=3 with out_ready=1 -> out_instr=0x00221820, out_addr=0x00400000, then done pulse.
REQ-042 prog_len=3; LW rt=8, rs=29, imm=4; J target=0x10; LUI rt=1, rs=7, imm=0x1234, back-to-back -> the following, then done:
- 0x8FA80004 @base;
- 0x08000010 @base+4;
- 0x3C011234 @base+8.
REQ-043 out_ready=0 for 5 cycles with a word pending -> in_ready=0, out_instr/out_addr stable; on release the word transfers and the next descriptor is accepted the same cycle.
REQ-044 prog_len=2; descriptors SUB, mnem=20, ORI -> the following, then done:
- SUB at base;
- err pulse, no word for mnem=20;
- ORI at base+4.
REQ-045 base_addr=0xFFFFFFFC, prog_len=2 -> out_addr 0xFFFFFFFC then 0x00000000.
REQ-045a start with prog_len=0 -> done pulse two cycles after start, no words emitted.
REQ-046 reset asserted while out_valid=1 and out_ready=0 -> next cycle: out_valid=0, state IDLE, no done pulse; a subsequent start works normally.

Source files
------------

// File: rtl/instr_encoder.sv
// Program loader: encodes MIPS-style instruction descriptors into 32-bit words
// and emits them with sequential byte addresses for instruction-memory writes.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] prog_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] MN_SLT = 4'd5;
    localparam logic [3:0] MN_J   = 4'd6;
    localparam logic [3:0] MN_LUI = 4'd13;

    state_t      state_reg, state_next;
    logic [31:0] cur_addr_reg;
    logic [15:0] remaining_reg;
    logic        out_valid_reg;
    logic [31:0] out_instr_reg;
    logic [31:0] out_addr_reg;
    logic        err_reg;
    logic        done_reg;

    logic        slot_free;
    logic        consume;
    logic        legal;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] enc_word;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg == RUN) && (remaining_reg != 16'd0) && slot_free;
    assign consume   = in_ready && in_valid;
    assign legal     = !in_mnem[4];

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_addr  = out_addr_reg;
    assign err       = err_reg;
    assign done      = done_reg;

    // Field tables are indexed by the low mnemonic bits; bit 4 marks illegal codes.
    always_comb begin
        funct    = 6'h00;
        opcode   = 6'h00;
        enc_word = 32'h0;
        case (in_mnem[3:0])
            4'd0:    funct  = 6'h20;
            4'd1:    funct  = 6'h22;
            4'd2:    funct  = 6'h24;
            4'd3:    funct  = 6'h25;
            4'd4:    funct  = 6'h26;
            4'd5:    funct  = 6'h2A;
            4'd7:    opcode = 6'h04;
            4'd8:    opcode = 6'h08;
            4'd9:    opcode = 6'h0A;
            4'd10:   opcode = 6'h0C;
            4'd11:   opcode = 6'h0D;
            4'd12:   opcode = 6'h0E;
            4'd13:   opcode = 6'h0F;
            4'd14:   opcode = 6'h23;
            4'd15:   opcode = 6'h2B;
            default: opcode = 6'h02;
        endcase
        if (in_mnem[3:0] <= MN_SLT) begin
            enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b00000, funct};
        end else if (in_mnem[3:0] == MN_J) begin
            enc_word = {6'h02, in_target};
        end else begin
            enc_word = {opcode, (in_mnem[3:0] == MN_LUI) ? 5'd0 : in_rs, in_rt, in_imm};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (prog_len != 16'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if ((remaining_reg == 16'd0) && slot_free) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= 32'h0;
            remaining_reg <= 16'h0;
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'h0;
            out_addr_reg  <= 32'h0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= consume && !legal;
            done_reg  <= (state_reg == DONE);
            if ((state_reg == IDLE) && start && (prog_len != 16'd0)) begin
                cur_addr_reg  <= base_addr;
                remaining_reg <= prog_len;
            end
            // Illegal descriptors are consumed but leave address/count untouched.
            if (consume && legal) begin
                out_valid_reg <= 1'b1;
                out_instr_reg <= enc_word;
                out_addr_reg  <= cur_addr_reg;
                cur_addr_reg  <= cur_addr_reg + 32'd4;
                remaining_reg <= remaining_reg - 16'd1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule
